// File: rtl/debounce_fsm.sv
// Tick-sampled button debouncer: 2-flop synchronizer, four-state acceptance FSM,
// registered press/release pulses and a once-per-press long-hold pulse.
module debounce_fsm #(
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int              CW       = $clog2(STABLE_TICKS) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [15:0]     HOLD_MAX = 16'(LONG_TICKS);

    generate
        if (STABLE_TICKS < 2 || STABLE_TICKS > 255) begin : g_bad_stable
            $error("debounce_fsm: STABLE_TICKS out of range 2..255");
        end
        if (LONG_TICKS <= STABLE_TICKS || LONG_TICKS > 65535) begin : g_bad_long
            $error("debounce_fsm: LONG_TICKS out of range STABLE_TICKS+1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   hcnt, hcnt_nxt;
    logic          sync_q, s;
    logic          level_nxt, press_nxt, release_nxt, long_nxt;
    logic          held;

    // btn_in is asynchronous; only the second flop's output is ever sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_q <= btn_in;
            s      <= sync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LOW;
            cnt           <= '0;
            hcnt          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hcnt          <= hcnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
        end
    end

    assign held = (state == HIGH) || (state == WAIT_LOW);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hcnt_nxt    = hcnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;

        // Hold time accrues on every tick while accepted-high, saturating.
        if (tick && held && hcnt < HOLD_MAX) begin
            hcnt_nxt = hcnt + 16'd1;
            long_nxt = (hcnt == HOLD_MAX - 16'd1);
        end

        case (state)
            LOW: begin
                if (tick && s) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (tick) begin
                    if (!s) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                        hcnt_nxt  = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                    end
                end
            end
            HIGH: begin
                if (tick && !s) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT_LOW: begin
                if (tick) begin
                    if (s) begin
                        // Release bounce: back to HIGH without touching hcnt or pulsing.
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = LOW;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt     = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase

        // Keep the three pulses mutually exclusive; release wins over long-press.
        if (release_nxt) long_nxt = 1'b0;

        level_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
    end

endmodule

// File: doc/debounce_fsm.md
DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 Parameter STABLE_TICKS, default 4: consecutive differing samples required to accept a level change; legal range 2..255.
REQ-002 Parameter LONG_TICKS, default 200: ticks of accepted-high level before long_press fires; legal range STABLE_TICKS+1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  sample strobe, one clk cycle wide, driven by the team's timer counter done output.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing button level (1 = pressed).
REQ-007 btn_level  output  1  debounced button level.
REQ-008 press_pulse  output  1  one-cycle pulse on accepted 0->1 change.
REQ-009 release_pulse  output  1  one-cycle pulse on accepted 1->0 change.
REQ-010 long_press  output  1  one-cycle pulse once per press held LONG_TICKS ticks.

Function
REQ-011 btn_in shall pass through a 2-flop synchronizer; sync output s is the only sampled value; s lags btn_in by 2 clk edges.
REQ-012 Samples shall be taken only on cycles with tick=1; s is ignored when tick=0.
REQ-013 FSM states shall be LOW, WAIT_HIGH, HIGH, WAIT_LOW, with state register and counters in the same clock domain.
REQ-014 LOW: tick & s=1 -> WAIT_HIGH, stable count cnt=1; otherwise stay, cnt=0.
REQ-015 WAIT_HIGH: tick & s=0 -> LOW, cnt=0; tick & s=1 & cnt=STABLE_TICKS-1 -> HIGH; tick & s=1 otherwise -> cnt+1.
REQ-016 HIGH: tick & s=0 -> WAIT_LOW, cnt=1; otherwise stay.
REQ-017 WAIT_LOW: tick & s=1 -> HIGH, cnt=0; tick & s=0 & cnt=STABLE_TICKS-1 -> LOW; tick & s=0 otherwise -> cnt+1.
REQ-018 Any bounce (sample equal to accepted level) during WAIT_* shall restart the count; non-consecutive samples shall never accumulate.
REQ-019 btn_level shall be 1 exactly in states HIGH and WAIT_LOW, registered, changing on the clk edge that enters HIGH or LOW.
REQ-020 press_pulse shall be high for exactly the one cycle following the WAIT_HIGH->HIGH transition edge; release_pulse likewise for WAIT_LOW->LOW.
REQ-021 Hold counter hcnt, 16 bits, shall clear on entry to HIGH from WAIT_HIGH and increment on each tick while in HIGH or WAIT_LOW, saturating at LONG_TICKS.
REQ-022 long_press shall pulse one cycle when hcnt transitions to LONG_TICKS; no further long_press until the next accepted press.
REQ-023 A return WAIT_LOW->HIGH (bounce on release) shall not clear hcnt nor re-fire press_pulse.
REQ-024 cnt width shall be $clog2(STABLE_TICKS)+1 bits; cnt shall never exceed STABLE_TICKS-1.
REQ-025 press_pulse, release_pulse and long_press shall be mutually exclusive in any cycle.
REQ-026 With tick held at 1 continuously the block shall operate correctly, with sample rate equal to the clk rate.

Reset
REQ-027 reset=1 shall immediately force state LOW, cnt=0, hcnt=0, synchronizer flops 0, and all outputs 0, independent of clk.
REQ-028 Reset mid-WAIT_HIGH or mid-HIGH shall discard progress; no pulse shall be emitted on or after deassertion until the full STABLE_TICKS sequence is re-observed.
REQ-029 After reset deassertion, the first clk edge shall resume normal operation; btn_in held high through reset shall yield press_pulse after STABLE_TICKS ticks.

Verification
REQ-030 STABLE_TICKS=4, tick every 10 clk, btn_in 0->1 clean: press_pulse one cycle after the 4th tick with s=1; btn_level=1 the same cycle.
REQ-031 btn_in high for 3 ticks, low for 1 tick, high for 4 ticks: exactly one press_pulse, after the 8th tick; none earlier.
REQ-032 Release with a 2-tick bounce back high: btn_level stays 1, no release_pulse, no second press_pulse; clean 4-tick low then gives one release_pulse.
REQ-033 LONG_TICKS=10, hold pressed 25 ticks: exactly one long_press, 10 ticks after press_pulse; none when held 9 ticks.
REQ-034 Assert reset for 3 clk while in WAIT_HIGH at cnt=3: all outputs 0 during reset; btn_in still high gives press_pulse 4 ticks after deassertion.
REQ-035 tick tied to 1, btn_in toggling every clk for 50 clk: no pulses, btn_level remains 0.
